pipe_add_sub_n_bit: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor. The carry chain is split into STAGES equal segments with one register boundary per segment. Operands enter through a valid/ready handshake; results leave with carry-out and signed-overflow flags, in order, one per cycle at full throughput. It is the clocked successor to the combinational n-bit ripple adder and is used wherever wide adds must close timing on the lab FPGA boards.

---
 rtl/pipe_add_sub_n_bit_if.sv | 40 ++++
 rtl/pipe_add_sub_n_bit.sv | 137 +++++++++++++
 tb/tb_pipe_add_sub_n_bit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_add_sub_n_bit_if.sv
// Operand/result handshake bundle for pipe_add_sub_n_bit.
// The sat signal exists only when PIPE_ADD_SAT_EN is defined.
interface pipe_add_sub_n_bit_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         overflow;
`ifdef PIPE_ADD_SAT_EN
    logic         sat;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, sat
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, sat
    );
`else
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
`endif
endinterface

// File: rtl/pipe_add_sub_n_bit.sv
// Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES
// segments of W = N/STAGES bits, one register boundary per segment.
// Each stage register holds: the segment carry, the low sum bits finished
// so far, and only the operand bits the remaining upper segments still need.
// A single global enable stalls every stage (bubbles included) when the
// output register is full and not being taken.
// Optional: define PIPE_ADD_SAT_EN to clamp overflowing results to the
// signed limits and add the sat output flag.
module pipe_add_sub_n_bit #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipe_add_sub_n_bit_if.slave bus
);
    localparam int W = N / STAGES;

    logic         w_en;
    logic [N-1:0] w_b_eff;
    logic         w_c0;

    // Pipeline advances whenever the output slot is empty or being drained.
    assign w_en     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // Subtraction is a + ~b + !borrow_in; the inversion rides with the beat.
    assign w_b_eff = bus.sub ? ~bus.b : bus.b;
    assign w_c0    = bus.c_in ^ bus.sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still pending at this stage: [N-1 : k*W].
        localparam int AW = N - k * W;
        // Sum bits complete after this stage: [(k+1)*W-1 : 0].
        localparam int PW = (k + 1) * W;

        logic          w_v;
        logic [AW-1:0] w_a;
        logic [AW-1:0] w_bp;
        logic          w_c;
        logic [W:0]    w_seg;
        logic [PW-1:0] w_s;

        assign w_seg = {1'b0, w_a[W-1:0]} + {1'b0, w_bp[W-1:0]} + {{W{1'b0}}, w_c};

        if (k == 0) begin : g_src
            assign w_v  = bus.in_valid;
            assign w_a  = bus.a;
            assign w_bp = w_b_eff;
            assign w_c  = w_c0;
            assign w_s  = w_seg[W-1:0];
        end else begin : g_src
            assign w_v  = g_stage[k-1].g_mid.r_v;
            assign w_a  = g_stage[k-1].g_mid.r_a;
            assign w_bp = g_stage[k-1].g_mid.r_bp;
            assign w_c  = g_stage[k-1].g_mid.r_c;
            assign w_s  = {w_seg[W-1:0], g_stage[k-1].g_mid.r_s};
        end

        if (k < STAGES - 1) begin : g_mid
            logic             r_v;
            logic [AW-W-1:0]  r_a;
            logic [AW-W-1:0]  r_bp;
            logic             r_c;
            logic [PW-1:0]    r_s;

            // Intermediate segment register: carry, finished low bits, pending operands.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v  <= 1'b0;
                    r_a  <= '0;
                    r_bp <= '0;
                    r_c  <= 1'b0;
                    r_s  <= '0;
                end else if (w_en) begin
                    r_v  <= w_v;
                    r_a  <= w_a[AW-1:W];
                    r_bp <= w_bp[AW-1:W];
                    r_c  <= w_seg[W];
                    r_s  <= w_s;
                end
            end
        end else begin : g_last
            logic         r_v;
            logic [N-1:0] r_s;
            logic         r_c;
            logic         r_ovf;
            logic         w_ovf;
            logic [N-1:0] w_res;

            // Same-sign operands producing a different-sign result.
            assign w_ovf = (w_a[AW-1] == w_bp[AW-1]) && (w_s[N-1] != w_a[AW-1]);

`ifdef PIPE_ADD_SAT_EN
            logic r_sat;

            // Negative operands overflow toward the minimum, positive toward the maximum.
            assign w_res = !w_ovf     ? w_s :
                           w_a[AW-1]  ? {1'b1, {(N-1){1'b0}}} :
                                        {1'b0, {(N-1){1'b1}}};

            // Saturation flag travels with the final result.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sat <= 1'b0;
                end else if (w_en) begin
                    r_sat <= w_ovf;
                end
            end

            assign bus.sat = r_sat;
`else
            assign w_res = w_s;
`endif

            // Output register: result and unclamped flags, held while stalled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v   <= 1'b0;
                    r_s   <= '0;
                    r_c   <= 1'b0;
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_v   <= w_v;
                    r_s   <= w_res;
                    r_c   <= w_seg[W];
                    r_ovf <= w_ovf;
                end
            end

            assign bus.out_valid = r_v;
            assign bus.sum       = r_s;
            assign bus.c_out     = r_c;
            assign bus.overflow  = r_ovf;
        end
    end
endmodule

// File: tb/tb_pipe_add_sub_n_bit.sv
// Bench for pipe_add_sub_n_bit: scoreboard on a STAGES=2 instance, plus
// STAGES=1 and STAGES=4 instances checked for latency and results.
module tb_pipe_add_sub_n_bit;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_add_sub_n_bit_if #(.N(8)) m ();
    pipe_add_sub_n_bit_if #(.N(8)) a1 ();
    pipe_add_sub_n_bit_if #(.N(8)) a4 ();

    pipe_add_sub_n_bit #(.N(8), .STAGES(2)) u_dut (.clk(clk), .reset(reset), .bus(m.slave));
    pipe_add_sub_n_bit #(.N(8), .STAGES(1)) u_s1  (.clk(clk), .reset(reset), .bus(a1.slave));
    pipe_add_sub_n_bit #(.N(8), .STAGES(4)) u_s4  (.clk(clk), .reset(reset), .bus(a4.slave));

    logic       x_valid;
    logic [7:0] x_a, x_b;
    logic       x_cin, x_sub;
    logic       m_sat, a1_sat, a4_sat;

    assign a1.in_valid = x_valid;
    assign a1.a = x_a;
    assign a1.b = x_b;
    assign a1.c_in = x_cin;
    assign a1.sub = x_sub;
    assign a1.out_ready = 1'b1;
    assign a4.in_valid = x_valid;
    assign a4.a = x_a;
    assign a4.b = x_b;
    assign a4.c_in = x_cin;
    assign a4.sub = x_sub;
    assign a4.out_ready = 1'b1;

`ifdef PIPE_ADD_SAT_EN
    localparam bit SAT = 1'b1;
    assign m_sat  = m.sat;
    assign a1_sat = a1.sat;
    assign a4_sat = a4.sat;
`else
    localparam bit SAT = 1'b0;
    assign m_sat  = 1'b0;
    assign a1_sat = 1'b0;
    assign a4_sat = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
        logic       st;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one beat on the main DUT; expectation queued at the accepting edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts,
                        input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        bit   done;
        e.s  = es;
        e.c  = ec;
        e.o  = eo;
        e.st = 1'b0;
        if (SAT && eo) begin
            e.s  = ta[7] ? 8'h80 : 8'h7F;
            e.st = 1'b1;
        end
        m.in_valid = 1'b1;
        m.a = ta;
        m.b = tb_;
        m.c_in = tc;
        m.sub = ts;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (m.in_ready) begin
                q.push_back(e);
                acc_cyc = cyc;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        m.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_left", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic alt_chk(input string nm, input int lat, input int d, input logic v,
                           input logic [7:0] s, input logic c, input logic o, input logic st);
        logic ev;
        ev = (d == lat) || (d == lat + 1);
        chk({nm, "_valid"}, v, ev);
        if (ev) begin
            if (d == lat) begin
                chk({nm, "_sum0"}, s, 8'h00);
                chk({nm, "_cout0"}, c, 1'b1);
                chk({nm, "_ovf0"}, o, 1'b0);
                if (SAT) chk({nm, "_sat0"}, st, 1'b0);
            end else begin
                chk({nm, "_sum1"}, s, SAT ? 8'h7F : 8'h80);
                chk({nm, "_cout1"}, c, 1'b0);
                chk({nm, "_ovf1"}, o, 1'b1);
                if (SAT) chk({nm, "_sat1"}, st, 1'b1);
            end
        end
    endtask

    // Monitor: pop on every output handshake; verify held outputs during stalls.
    logic       have_hold = 1'b0;
    logic [7:0] hold_sum;
    logic       hold_c, hold_o, hold_st;
    exp_t       got_e;

    always @(negedge clk) begin
        if (reset) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                chk("hold_valid", m.out_valid, 1'b1);
                chk("hold_sum", m.sum, hold_sum);
                chk("hold_cout", m.c_out, hold_c);
                chk("hold_ovf", m.overflow, hold_o);
                if (SAT) chk("hold_sat", m_sat, hold_st);
            end
            if (m.out_valid && m.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: got sum 0x%0h, expected no output", m.sum);
                end else begin
                    got_e = q.pop_front();
                    chk("sb_sum", m.sum, got_e.s);
                    chk("sb_cout", m.c_out, got_e.c);
                    chk("sb_ovf", m.overflow, got_e.o);
                    if (SAT) chk("sb_sat", m_sat, got_e.st);
                end
            end
            have_hold = m.out_valid && !m.out_ready;
            hold_sum  = m.sum;
            hold_c    = m.c_out;
            hold_o    = m.overflow;
            hold_st   = m_sat;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_lat;
        int t0;
        int d;
        reset = 1'b1;
        m.in_valid = 1'b0;
        m.a = '0;
        m.b = '0;
        m.c_in = 1'b0;
        m.sub = 1'b0;
        m.out_ready = 1'b1;
        x_valid = 1'b0;
        x_a = '0;
        x_b = '0;
        x_cin = 1'b0;
        x_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", m.out_valid, 1'b0);
        chk("rst_sum", m.sum, 8'h00);
        chk("rst_cout", m.c_out, 1'b0);
        chk("rst_ovf", m.overflow, 1'b0);
        chk("rst_in_ready", m.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Scenario 1 with latency measurement.
        send(8'h7F, 8'h80, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        got_lat = -1;
        for (int i = 0; i < 10 && got_lat < 0; i++) begin
            @(negedge clk);
            if (m.out_valid) got_lat = cyc - acc_cyc;
        end
        chk("t1_latency", got_lat, 2);
        @(posedge clk);
        #1;

        // Add/sub vectors, mode changing between consecutive beats.
        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        send(8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0);
        send(8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        drain();

        // Scenario 4: back-to-back stream with a 3-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(8'(8'h10 + i), 8'h01, 1'b0, 1'b0, 8'(8'h11 + i), 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                m.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", m.in_ready, 1'b0);
                    @(posedge clk);
                    #1;
                end
                m.out_ready = 1'b1;
            end
        join
        drain();

        // Scenario 5: two beats in flight, then reset discards them.
        m.out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
        send(8'h04, 8'h05, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        m.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_out_valid", m.out_valid, 1'b0);
        chk("t5_in_ready", m.in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_ghost", m.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send(8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
        drain();

        // Scenario 6: STAGES=1 and STAGES=4 on the scenario 2 vectors.
        x_valid = 1'b1;
        x_a = 8'hFF;
        x_b = 8'h01;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk);
        #1;
        x_a = 8'h7F;
        x_b = 8'h01;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            d = cyc - t0;
            alt_chk("s1", 1, d, a1.out_valid, a1.sum, a1.c_out, a1.overflow, a1_sat);
            alt_chk("s4", 4, d, a4.out_valid, a4.sum, a4.c_out, a4.overflow, a4_sat);
            @(posedge clk);
            #1;
            x_valid = 1'b0;
        end

        chk("final_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
